// File: rtl/crc_frame_checker_if.sv
// ============================================================================
// Module   : crc_frame_checker_if
// Brief    : Byte-stream and status bundle between the receive path, the CRC
//            frame checker and the status display decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface crc_frame_checker_if;
   logic       start_in;
   logic [7:0] byte_in;
   logic       byte_valid_in;
   logic       ready_out;
   logic [1:0] status_out;
   logic       done_out;
   logic [7:0] crc_out;

   modport master (
      output start_in,
      output byte_in,
      output byte_valid_in,
      input  ready_out,
      input  status_out,
      input  done_out,
      input  crc_out
   );

   modport slave (
      input  start_in,
      input  byte_in,
      input  byte_valid_in,
      output ready_out,
      output status_out,
      output done_out,
      output crc_out
   );
endinterface

`default_nettype wire

// File: rtl/crc_frame_checker.sv
// ============================================================================
// Module   : crc_frame_checker
// Brief    : Fixed-length CRC-8 frame checker driving the 2-bit display status.
//            Optional in-frame idle timeout enabled by macro CRC_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module crc_frame_checker #(
   parameter int unsigned DATA_BYTES     = 4,
   parameter logic [7:0]  CRC_POLY       = 8'h07,
   parameter logic [7:0]  CRC_INIT       = 8'h00,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input logic                clk,
   input logic                rst,
   crc_frame_checker_if.slave bus
);
   localparam int unsigned        C_CNT_W   = $clog2(DATA_BYTES + 2);
   localparam logic [C_CNT_W-1:0] C_LAST    = C_CNT_W'(DATA_BYTES);
   localparam logic [1:0]         C_ST_ERR  = 2'b00;
   localparam logic [1:0]         C_ST_OK   = 2'b01;
   localparam logic [1:0]         C_ST_BUSY = 2'b10;
   localparam logic [1:0]         C_ST_IDLE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_CHECK = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t               r_state,  w_state_next;
   logic [7:0]           r_crc,    w_crc_next;
   logic [C_CNT_W-1:0]   r_count,  w_count_next;
   logic [1:0]           r_status, w_status_next;
   logic                 r_done,   w_done_next;
   logic                 w_accept;
   logic                 w_timeout;

   if (DATA_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("crc_frame_checker: DATA_BYTES and TIMEOUT_CYCLES must be >= 1");
   end

   // Eight MSB-first shift/XOR steps, unrolled into one cycle.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

   // A restart in the same cycle wins over any byte on the bus.
   assign w_accept = (r_state == S_RECV) && bus.byte_valid_in && !bus.start_in;

`ifdef CRC_TIMEOUT_EN
   localparam int unsigned       C_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [C_IDLE_W-1:0] C_IDLE_LAST = C_IDLE_W'(TIMEOUT_CYCLES - 1);

   logic [C_IDLE_W-1:0] r_idle;

   always_ff @(posedge clk) begin
      if (rst || r_state != S_RECV || bus.start_in || w_accept) begin
         r_idle <= '0;
      end else begin
         r_idle <= r_idle + 1'b1;
      end
   end

   assign w_timeout = (r_state == S_RECV) && !bus.start_in && !w_accept
                      && (r_idle == C_IDLE_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_next  = r_state;
      w_crc_next    = r_crc;
      w_count_next  = r_count;
      w_status_next = r_status;
      w_done_next   = 1'b0;
      case (r_state)
         S_IDLE, S_HOLD: begin
            if (bus.start_in) begin
               w_state_next  = S_RECV;
               w_crc_next    = CRC_INIT;
               w_count_next  = '0;
               w_status_next = C_ST_BUSY;
            end
         end
         S_RECV: begin
            if (bus.start_in) begin
               w_crc_next   = CRC_INIT;
               w_count_next = '0;
            end else if (w_accept) begin
               w_crc_next   = crc8_byte(r_crc, bus.byte_in);
               w_count_next = r_count + 1'b1;
               if (r_count == C_LAST) begin
                  w_state_next = S_CHECK;
               end
            end else if (w_timeout) begin
               w_status_next = C_ST_ERR;
               w_done_next   = 1'b1;
               w_state_next  = S_HOLD;
            end
         end
         S_CHECK: begin
            w_status_next = (r_crc == 8'h00) ? C_ST_OK : C_ST_ERR;
            w_done_next   = 1'b1;
            w_state_next  = S_HOLD;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_crc    <= 8'h00;
         r_count  <= '0;
         r_status <= C_ST_IDLE;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_crc    <= w_crc_next;
         r_count  <= w_count_next;
         r_status <= w_status_next;
         r_done   <= w_done_next;
      end
   end

   assign bus.ready_out  = (r_state == S_RECV);
   assign bus.status_out = r_status;
   assign bus.done_out   = r_done;
   assign bus.crc_out    = r_crc;
endmodule

`default_nettype wire
